instruction_sequencer: RTL and testbench
========================================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Clock  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-low reset; low forces reset state immediately, independent of Clock.
REQ-003 iEnable  input  1  run enable; 1 = fetch/execute program, 0 = park in IDLE.
REQ-004 oAddress  output  16  program counter (PC); drives the instruction ROM iAddress.
REQ-005 iInstruction  input  28  instruction word from the ROM, combinational from oAddress, valid in the same cycle.
REQ-006 oInstruction  output  28  registered copy of the last issued instruction, for the execute unit.
REQ-007 oIssue  output  1  one-cycle pulse; oInstruction is new and must be executed.
REQ-008 iExecBusy  input  1  execute unit busy with a multi-cycle operation (e.g. MUL); stalls the sequencer.
REQ-009 oWaiting  output  1  1 while a NOP delay is counting.

Function
REQ-010 Fields SHALL be: opcode = iInstruction[27:24]; NOP delay imm24 = [23:0]; JMP target imm16 = [15:0].
REQ-011 FSM states SHALL be IDLE, FETCH, DELAY, WAIT_EXEC.
REQ-012 IDLE: PC held; go to FETCH when iEnable=1, else stay.
REQ-013 FETCH with iEnable=0: go to IDLE; PC unchanged; no issue.
REQ-014 FETCH, opcode NOP, imm24=0: PC<=PC+1; stay in FETCH (1 cycle total).
REQ-015 FETCH, opcode NOP, imm24=N>0: load delay counter with N; go to DELAY; PC unchanged.
REQ-016 DELAY: oWaiting=1; counter decrements each cycle; on the cycle the counter equals 1, PC<=PC+1 and go to FETCH. A NOP with N>0 therefore occupies exactly N+1 cycles.
REQ-017 FETCH, opcode JMP: PC<=imm16; stay in FETCH; no issue (1 cycle). JMP to its own address loops indefinitely.
REQ-018 FETCH, any other opcode: oInstruction<=iInstruction; oIssue=1 for the next cycle only; PC<=PC+1; go to WAIT_EXEC.
REQ-019 WAIT_EXEC: minimum one cycle; go to FETCH on the first cycle iExecBusy=0, else stay. Every issued instruction therefore takes at least 2 cycles.
REQ-020 iExecBusy SHALL be ignored in all states other than WAIT_EXEC.
REQ-021 iEnable SHALL be ignored in DELAY and WAIT_EXEC; the current instruction completes first, and the deassertion takes effect at the next FETCH.
REQ-022 PC increment SHALL wrap 16'hFFFF -> 16'h0000.
REQ-023 oAddress, oInstruction, oIssue and oWaiting SHALL be registered outputs.

Reset
REQ-024 Reset low SHALL force: state=IDLE, oAddress=0, oInstruction=0, oIssue=0, oWaiting=0, delay counter=0.
REQ-025 Reset asserted mid-DELAY or mid-WAIT_EXEC SHALL abort the operation with no further oIssue; after release, execution restarts from address 0.

Structure
REQ-026 Opcode encodings (NOP, JMP, STO, MUL, LED, ...), field bit positions and the FSM state encodings SHALL live in the shared definitions file used by the ROM and ALU.
REQ-027 The 24-bit loadable down-counter SHALL be a sub-module, delay_counter (ports: load, value, tick, last).
REQ-028 The target size is 120-400 lines of RTL; no other sub-modules.

Verification
REQ-029 Reset released, iEnable=1, ROM[0]=NOP 3, ROM[1]=STO R0,37748 -> oAddress=0 for 4 cycles, oWaiting=1 for 3 of them, then oAddress=1, then a single oIssue pulse with oInstruction=ROM[1].
REQ-030 ROM[7]=JMP 0 -> the cycle after address 7, oAddress=0; no oIssue for the JMP.
REQ-031 ROM[4]=MUL, iExecBusy=1 for 5 cycles after issue -> oAddress=5 held, no new oIssue until the cycle after iExecBusy falls.
REQ-032 ROM[n]=NOP 0 -> oAddress advances n->n+1 in one cycle; oWaiting stays 0.
REQ-033 Reset driven low during DELAY with counter=2000 -> all outputs 0 immediately, before the next Clock edge; after release with iEnable=1, fetch resumes at 0.
REQ-034 PC=16'hFFFF holding a non-jump instruction, iExecBusy=0 -> issue pulse, then oAddress=16'h0000.

Source files
------------

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the sequencer, ROM and ALU: opcodes, field positions,
// FSM state encoding and small field-extraction helpers.
package instruction_sequencer_pkg;

  localparam int ADDR_W   = 16;
  localparam int INSTR_W  = 28;
  localparam int OPCODE_W = 4;
  localparam int IMM24_W  = 24;
  localparam int IMM16_W  = 16;

  localparam int OPCODE_LSB = 24;
  localparam int OPCODE_MSB = 27;
  localparam int IMM24_MSB  = 23;
  localparam int IMM16_MSB  = 15;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_STO = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_MUL = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_LED = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH     = 2'd1,
    ST_DELAY     = 2'd2,
    ST_WAIT_EXEC = 2'd3
  } seq_state_t;

  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [IMM24_W-1:0] get_imm24(input logic [INSTR_W-1:0] instr);
    return instr[IMM24_MSB:0];
  endfunction

  function automatic logic [IMM16_W-1:0] get_imm16(input logic [INSTR_W-1:0] instr);
    return instr[IMM16_MSB:0];
  endfunction

  // The program counter wraps naturally at 16 bits.
  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/instruction_sequencer_delay_counter.sv
// 24-bit loadable down-counter timing NOP delays; 'last' marks the final
// waiting cycle (count == 1).
module delay_counter
  import instruction_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [IMM24_W-1:0] value,
  input  logic               tick,
  output logic               last
);

  logic [IMM24_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (tick && (count != '0)) begin
      count <= count - 24'd1;
    end
  end

  assign last = (count == 24'd1);

endmodule

// File: rtl/instruction_sequencer.sv
// Program sequencer: fetches from the instruction ROM, handles NOP delays and
// jumps locally, and issues all other instructions to the execute unit.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iEnable,
  output logic [ADDR_W-1:0]  oAddress,
  input  logic [INSTR_W-1:0] iInstruction,
  output logic [INSTR_W-1:0] oInstruction,
  output logic               oIssue,
  input  logic               iExecBusy,
  output logic               oWaiting
);

  seq_state_t          state;
  logic [OPCODE_W-1:0] opcode;
  logic [IMM24_W-1:0]  imm24;
  logic [IMM16_W-1:0]  imm16;
  logic                delay_load;
  logic                delay_tick;
  logic                delay_last;

  assign opcode = get_opcode(iInstruction);
  assign imm24  = get_imm24(iInstruction);
  assign imm16  = get_imm16(iInstruction);

  // Counter is armed in the same FETCH cycle that moves the FSM into DELAY.
  assign delay_load = (state == ST_FETCH) && iEnable && (opcode == OP_NOP) && (imm24 != '0);
  assign delay_tick = (state == ST_DELAY);

  delay_counter u_delay_counter (
    .clk   (Clock),
    .rst_n (Reset),
    .load  (delay_load),
    .value (imm24),
    .tick  (delay_tick),
    .last  (delay_last)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= ST_IDLE;
      oAddress     <= '0;
      oInstruction <= '0;
      oIssue       <= 1'b0;
      oWaiting     <= 1'b0;
    end else begin
      oIssue <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iEnable) begin
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!iEnable) begin
            state <= ST_IDLE;
          end else if (opcode == OP_NOP) begin
            if (imm24 == '0) begin
              oAddress <= pc_next(oAddress);
            end else begin
              state    <= ST_DELAY;
              oWaiting <= 1'b1;
            end
          end else if (opcode == OP_JMP) begin
            oAddress <= imm16;
          end else begin
            oInstruction <= iInstruction;
            oIssue       <= 1'b1;
            oAddress     <= pc_next(oAddress);
            state        <= ST_WAIT_EXEC;
          end
        end
        ST_DELAY: begin
          if (delay_last) begin
            oAddress <= pc_next(oAddress);
            oWaiting <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        ST_WAIT_EXEC: begin
          if (!iExecBusy) begin
            state <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench: a modelled ROM, table-driven single-instruction probes
// scored through an issue queue, plus hand-written reset/enable/wrap sequences.
module tb_instruction_sequencer;
  import instruction_sequencer_pkg::*;

  logic               Clock = 1'b0;
  logic               Reset = 1'b1;
  logic               iEnable = 1'b0;
  logic               iExecBusy = 1'b0;
  logic [ADDR_W-1:0]  oAddress;
  logic [INSTR_W-1:0] iInstruction;
  logic [INSTR_W-1:0] oInstruction;
  logic               oIssue;
  logic               oWaiting;

  logic [INSTR_W-1:0] rom [0:65535];

  typedef struct {
    logic [INSTR_W-1:0] instr;
    int                 exp_cycle;
  } issue_t;

  typedef struct {
    string              name;
    logic [INSTR_W-1:0] instr;
    int                 busy_len;
    logic               busy_force;
    logic [ADDR_W-1:0]  exp_next;
    int                 exp_len;
    int                 exp_wait;
    logic               exp_issue;
  } vec_t;

  issue_t      sb[$];
  vec_t        vecs[9];
  int          checks = 0;
  int          failures = 0;
  int          cyc;
  int          wait_cnt;
  int          spurious;
  int          busy_left;
  logic [15:0] addr_log [0:127];

  instruction_sequencer dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iEnable      (iEnable),
    .oAddress     (oAddress),
    .iInstruction (iInstruction),
    .oInstruction (oInstruction),
    .oIssue       (oIssue),
    .iExecBusy    (iExecBusy),
    .oWaiting     (oWaiting)
  );

  assign iInstruction = rom[oAddress];

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [INSTR_W-1:0] mk_nop(input logic [23:0] n);
    return {OP_NOP, n};
  endfunction

  function automatic logic [INSTR_W-1:0] mk_jmp(input logic [15:0] t);
    return {OP_JMP, 8'h00, t};
  endfunction

  function automatic logic [INSTR_W-1:0] mk_led(input logic [15:0] v);
    return {OP_LED, 8'h5A, v};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Every unused ROM word jumps to itself, so a stray jump stalls silently.
  task automatic start_run();
    Reset = 1'b0;
    iEnable = 1'b0;
    iExecBusy = 1'b0;
    busy_left = 0;
    for (int a = 0; a < 65536; a++) rom[a] = mk_jmp(16'(a));
    sb.delete();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    iEnable = 1'b1;
    Reset = 1'b1;
    cyc = 0;
    wait_cnt = 0;
    spurious = 0;
  endtask

  task automatic run_cycles(input string name, input int stop_cycle, input int budget,
                            input int busy_len, input logic busy_force);
    issue_t e;
    while (cyc < budget) begin
      @(posedge Clock);
      #1;
      cyc++;
      if (cyc < 128) addr_log[cyc] = oAddress;
      if (oWaiting) wait_cnt++;
      if (oIssue) begin
        if (sb.size() == 0) begin
          spurious++;
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("%s_issue_cycle", name), cyc, e.exp_cycle);
          checkOutput($sformatf("%s_issue_instr", name), oInstruction, e.instr);
        end
        busy_left = busy_len;
      end
      iExecBusy = busy_force || (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if ((sb.size() == 0) && (cyc >= stop_cycle)) break;
    end
  endtask

  // Instruction under test at address 0, an LED marker at the expected next PC.
  task automatic applyStimulus(input vec_t v);
    int mism;
    logic [15:0] exp_addr;
    start_run();
    rom[0] = v.instr;
    rom[v.exp_next] = mk_led(v.exp_next);
    iExecBusy = v.busy_force;
    if (v.exp_issue) sb.push_back('{v.instr, 2});
    sb.push_back('{mk_led(v.exp_next), v.exp_len + 2});
    run_cycles(v.name, v.exp_len + 2, v.exp_len + 14, v.busy_len, v.busy_force);
    checkOutput($sformatf("%s_sb_drain", v.name), sb.size(), 0);
    checkOutput($sformatf("%s_spurious", v.name), spurious, 0);
    checkOutput($sformatf("%s_wait_cycles", v.name), wait_cnt, v.exp_wait);
    checkOutput($sformatf("%s_next_addr", v.name), addr_log[v.exp_len + 1], v.exp_next);
    mism = 0;
    for (int c = 1; c <= v.exp_len; c++) begin
      exp_addr = (v.exp_issue && c >= 2) ? v.exp_next : 16'h0000;
      if (addr_log[c] !== exp_addr) mism++;
    end
    checkOutput($sformatf("%s_addr_trace", v.name), mism, 0);
  endtask

  initial begin
    vecs[0] = '{"nop0",        mk_nop(24'd0),                    0, 1'b0, 16'h0001, 1, 0, 1'b0};
    vecs[1] = '{"nop3",        mk_nop(24'd3),                    0, 1'b0, 16'h0001, 4, 3, 1'b0};
    vecs[2] = '{"nop1_busy",   mk_nop(24'd1),                    0, 1'b1, 16'h0001, 2, 1, 1'b0};
    vecs[3] = '{"jmp7",        mk_jmp(16'h0007),                 0, 1'b0, 16'h0007, 1, 0, 1'b0};
    vecs[4] = '{"jmp1234_busy", mk_jmp(16'h1234),                0, 1'b1, 16'h1234, 1, 0, 1'b0};
    vecs[5] = '{"sto",         {OP_STO, 4'h0, 4'h0, 16'd37748},  0, 1'b0, 16'h0001, 2, 0, 1'b1};
    vecs[6] = '{"mul_busy5",   {OP_MUL, 4'h1, 4'h2, 16'h0000},   5, 1'b0, 16'h0001, 7, 0, 1'b1};
    vecs[7] = '{"led_busy2",   {OP_LED, 8'h00, 16'h00A5},        2, 1'b0, 16'h0001, 4, 0, 1'b1};
    vecs[8] = '{"opF_busy1",   {4'hF, 24'h123456},               1, 1'b0, 16'h0001, 3, 0, 1'b1};

    // Asynchronous reset with no clock edge yet.
    #2 Reset = 1'b0;
    #1;
    checkOutput("reset_addr", oAddress, 0);
    checkOutput("reset_instr", oInstruction, 0);
    checkOutput("reset_issue", oIssue, 0);
    checkOutput("reset_waiting", oWaiting, 0);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Reset in the middle of a 2000-cycle NOP delay.
    start_run();
    rom[0] = mk_jmp(16'h0040);
    rom[16'h0040] = mk_nop(24'd2000);
    run_cycles("rst_delay", 3, 3, 0, 1'b0);
    checkOutput("rst_delay_pre_addr", oAddress, 16'h0040);
    checkOutput("rst_delay_pre_waiting", oWaiting, 1);
    #2 Reset = 1'b0;
    #1;
    checkOutput("rst_delay_addr", oAddress, 0);
    checkOutput("rst_delay_waiting", oWaiting, 0);
    checkOutput("rst_delay_issue", oIssue, 0);
    @(negedge Clock);
    Reset = 1'b1;
    run_cycles("rst_delay_restart", 6, 6, 0, 1'b0);
    checkOutput("rst_delay_restart_addr0", addr_log[4], 16'h0000);
    checkOutput("rst_delay_restart_addr1", addr_log[5], 16'h0040);
    checkOutput("rst_delay_restart_waiting", oWaiting, 1);

    // Reset while the execute unit holds the sequencer in WAIT_EXEC.
    start_run();
    rom[0] = {OP_MUL, 4'h3, 4'h4, 16'h0000};
    rom[1] = mk_led(16'h0001);
    sb.push_back('{rom[0], 2});
    run_cycles("rst_exec", 3, 3, 10, 1'b0);
    checkOutput("rst_exec_pre_addr", oAddress, 1);
    #2 Reset = 1'b0;
    #1;
    checkOutput("rst_exec_addr", oAddress, 0);
    checkOutput("rst_exec_instr", oInstruction, 0);
    checkOutput("rst_exec_issue", oIssue, 0);
    @(negedge Clock);
    Reset = 1'b1;
    sb.push_back('{rom[0], 5});
    run_cycles("rst_exec_restart", 5, 10, 0, 1'b0);
    checkOutput("rst_exec_sb_drain", sb.size(), 0);
    checkOutput("rst_exec_spurious", spurious, 0);

    // Enable dropped mid-delay: the NOP completes, then the next FETCH parks.
    start_run();
    rom[0] = mk_nop(24'd3);
    rom[1] = mk_led(16'h0001);
    run_cycles("en_drop", 2, 2, 0, 1'b0);
    iEnable = 1'b0;
    run_cycles("en_drop", 8, 8, 0, 1'b0);
    checkOutput("en_drop_addr_c4", addr_log[4], 16'h0000);
    checkOutput("en_drop_addr_c5", addr_log[5], 16'h0001);
    checkOutput("en_drop_addr_c8", addr_log[8], 16'h0001);
    checkOutput("en_drop_wait_cycles", wait_cnt, 3);
    checkOutput("en_drop_spurious", spurious, 0);
    iEnable = 1'b1;
    sb.push_back('{mk_led(16'h0001), 10});
    run_cycles("en_resume", 10, 20, 0, 1'b0);
    checkOutput("en_resume_sb_drain", sb.size(), 0);

    // PC wrap from 16'hFFFF after an issued instruction.
    start_run();
    rom[0] = mk_jmp(16'hFFFF);
    rom[16'hFFFF] = {OP_LED, 8'h00, 16'hBEEF};
    sb.push_back('{rom[16'hFFFF], 3});
    run_cycles("wrap", 3, 8, 0, 1'b0);
    checkOutput("wrap_addr_c2", addr_log[2], 16'hFFFF);
    checkOutput("wrap_addr_c3", addr_log[3], 16'h0000);
    checkOutput("wrap_sb_drain", sb.size(), 0);
    checkOutput("wrap_spurious", spurious, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
